// File: rtl/lfsr_sample_fifo.sv
// Decimating sample capture of the LFSR output into a circular FWFT FIFO with an AXI-Stream master.
// Optional build macro: LFSR_SAMPLE_DROP_CNT_EN enables the saturating drop_count register.
module lfsr_sample_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int DIV_WIDTH  = 8
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     sample_en,
    input  logic [DATA_WIDTH-1:0]    lfsr_data,
    input  logic [DIV_WIDTH-1:0]     div,
    input  logic                     flush,
    input  logic                     clr_ovf,
    output logic [DATA_WIDTH-1:0]    m_axis_tdata,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [7:0]               drop_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [DIV_WIDTH-1:0]  dcnt;
    logic [LVL_W-1:0]      level_q;

    logic capture;
    logic full;
    logic pop_req;
    logic pop;
    logic push;
    logic drop;

    // Handshake: a beat transfers on any edge where m_axis_tvalid && m_axis_tready;
    // tvalid never drops and tdata never changes without a transfer, except on flush or reset.
    assign m_axis_tvalid = (level_q != '0);
    assign m_axis_tdata  = mem[rd_ptr];
    assign level         = level_q;

    always_comb begin
        capture = sample_en && (dcnt >= div);
        full    = (level_q == LVL_FULL);
        pop_req = m_axis_tvalid && m_axis_tready;
        // flush discards everything in flight, including this cycle's capture and pop
        pop     = pop_req && !flush;
        push    = capture && (!full || pop_req) && !flush;
        drop    = capture && full && !pop_req && !flush;
    end

    // Decimation counter: >= lets a lowered div take effect on the current count
    always_ff @(posedge clk) begin
        if (!resetn) begin
            dcnt <= '0;
        end else if (flush) begin
            dcnt <= '0;
        end else if (sample_en) begin
            if (capture) begin
                dcnt <= '0;
            end else begin
                dcnt <= dcnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (resetn && push) begin
            mem[wr_ptr] <= lfsr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn || flush) begin
            level_q <= '0;
        end else begin
            case ({push, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    // A drop in the same cycle as clr_ovf wins
    always_ff @(posedge clk) begin
        if (!resetn) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

`ifdef LFSR_SAMPLE_DROP_CNT_EN
    logic [7:0] drop_cnt_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            drop_cnt_q <= 8'h00;
        end else if (drop) begin
            if (clr_ovf) begin
                drop_cnt_q <= 8'h01;
            end else if (drop_cnt_q != 8'hFF) begin
                drop_cnt_q <= drop_cnt_q + 8'h01;
            end
        end else if (clr_ovf) begin
            drop_cnt_q <= 8'h00;
        end
    end

    assign drop_count = drop_cnt_q;
`else
    assign drop_count = 8'h00;
`endif

endmodule

// File: tb/tb_lfsr_sample_fifo.sv
// Self-checking bench for lfsr_sample_fifo: directed scenarios plus randomized traffic against a queue model.
module tb_lfsr_sample_fifo;

    localparam int DATA_WIDTH = 8;
    localparam int DEPTH      = 16;
    localparam int DIV_WIDTH  = 8;
`ifdef LFSR_SAMPLE_DROP_CNT_EN
    localparam bit DC_EN = 1'b1;
`else
    localparam bit DC_EN = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   resetn = 1'b0;
    logic                   sample_en = 1'b0;
    logic [DATA_WIDTH-1:0]  lfsr_data = '0;
    logic [DIV_WIDTH-1:0]   div = '0;
    logic                   flush = 1'b0;
    logic                   clr_ovf = 1'b0;
    logic [DATA_WIDTH-1:0]  m_axis_tdata;
    logic                   m_axis_tvalid;
    logic                   m_axis_tready = 1'b0;
    logic [$clog2(DEPTH):0] level;
    logic                   overflow;
    logic [7:0]             drop_count;

    int checks = 0;
    int errors = 0;

    // Reference model: expected FIFO contents and sticky status
    logic [DATA_WIDTH-1:0] exp_q[$];
    int since = 0;
    bit m_ovf = 1'b0;
    int m_drops = 0;

    lfsr_sample_fifo #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH(DEPTH),
        .DIV_WIDTH(DIV_WIDTH)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .sample_en(sample_en),
        .lfsr_data(lfsr_data),
        .div(div),
        .flush(flush),
        .clr_ovf(clr_ovf),
        .m_axis_tdata(m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .level(level),
        .overflow(overflow),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    function automatic int exp_dc();
        return DC_EN ? m_drops : 0;
    endfunction

    // Advance one clock edge, update the model from the inputs seen at that edge, settle 1ns.
    task automatic step();
        bit pop, cap, full, drop;
        @(posedge clk);
        if (!resetn) begin
            exp_q.delete();
            since = 0;
            m_ovf = 1'b0;
            m_drops = 0;
        end else begin
            pop  = (exp_q.size() != 0) && m_axis_tready;
            cap  = sample_en && (since >= int'(div));
            full = (exp_q.size() == DEPTH);
            drop = 1'b0;
            if (sample_en) since = cap ? 0 : since + 1;
            if (flush) begin
                exp_q.delete();
                since = 0;
            end else begin
                drop = cap && full && !pop;
                if (pop) void'(exp_q.pop_front());
                if (cap && !drop) exp_q.push_back(lfsr_data);
            end
            if (drop) begin
                m_ovf = 1'b1;
                m_drops = clr_ovf ? 1 : (m_drops < 255 ? m_drops + 1 : 255);
            end else if (clr_ovf) begin
                m_ovf = 1'b0;
                m_drops = 0;
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        sample_en = 1'b0;
        flush = 1'b0;
        clr_ovf = 1'b0;
        m_axis_tready = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        idle_inputs();
        step();
        step();
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %b want 0", m_axis_tvalid); end
        checks++; if (level !== 5'd0) begin errors++; $display("FAIL reset_level got %0d want 0", level); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
        checks++; if (drop_count !== 8'h00) begin errors++; $display("FAIL reset_drop_count got %h want 00", drop_count); end
        resetn = 1'b1;
        step();
    endtask

    task automatic test_fill_drain();
        div = 8'd0;
        m_axis_tready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sample_en = 1'b1;
            lfsr_data = 8'(8'h10 + i);
            step();
        end
        sample_en = 1'b0;
        checks++; if (level !== 5'd4) begin errors++; $display("FAIL fill_level got %0d want 4", level); end
        checks++; if (m_axis_tdata !== 8'h10) begin errors++; $display("FAIL fill_head got %h want 10", m_axis_tdata); end
        m_axis_tready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 8'(8'h10 + i)) begin
                errors++; $display("FAIL drain_data[%0d] got v=%b d=%h want v=1 d=%h", i, m_axis_tvalid, m_axis_tdata, 8'(8'h10 + i));
            end
            step();
        end
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL drain_tvalid got %b want 0", m_axis_tvalid); end
        checks++; if (level !== 5'd0) begin errors++; $display("FAIL drain_level got %0d want 0", level); end
        m_axis_tready = 1'b0;
    endtask

    task automatic test_decimation();
        logic [DATA_WIDTH-1:0] got[$];
        logic [DATA_WIDTH-1:0] want[$];
        want = '{8'h02, 8'h05, 8'h08};
        div = 8'd2;
        m_axis_tready = 1'b1;
        sample_en = 1'b1;
        for (int i = 0; i < 9; i++) begin
            lfsr_data = 8'(i);
            step();
            if (m_axis_tvalid) got.push_back(m_axis_tdata);
        end
        checks++; if (got.size() != 3) begin errors++; $display("FAIL decim_count got %0d want 3", got.size()); end
        for (int i = 0; i < 3; i++) begin
            if (i < got.size()) begin
                checks++;
                if (got[i] !== want[i]) begin errors++; $display("FAIL decim_data[%0d] got %h want %h", i, got[i], want[i]); end
            end
        end
        sample_en = 1'b0;
        for (int i = 0; i < 3; i++) step();
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL decim_pause_tvalid got %b want 0", m_axis_tvalid); end
        sample_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            lfsr_data = 8'(8'hA0 + k);
            step();
            if (k < 2) begin
                checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL decim_resume_early[%0d] got %b want 0", k, m_axis_tvalid); end
            end
        end
        checks++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 8'hA2) begin
            errors++; $display("FAIL decim_resume got v=%b d=%h want v=1 d=a2", m_axis_tvalid, m_axis_tdata);
        end
        sample_en = 1'b0;
        step();
        m_axis_tready = 1'b0;
    endtask

    task automatic test_overflow();
        div = 8'd0;
        m_axis_tready = 1'b0;
        sample_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            lfsr_data = 8'(i);
            step();
        end
        sample_en = 1'b0;
        checks++; if (level !== 5'd16) begin errors++; $display("FAIL ovf_level got %0d want 16", level); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", overflow); end
        checks++; if (drop_count !== (DC_EN ? 8'd4 : 8'd0)) begin errors++; $display("FAIL ovf_drop_count got %0d want %0d", drop_count, DC_EN ? 4 : 0); end
        m_axis_tready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 8'(i)) begin
                errors++; $display("FAIL ovf_drain[%0d] got v=%b d=%h want v=1 d=%h", i, m_axis_tvalid, m_axis_tdata, 8'(i));
            end
            step();
        end
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL ovf_drain_end got %b want 0", m_axis_tvalid); end
        m_axis_tready = 1'b0;
    endtask

    task automatic test_full_pop();
        logic [DATA_WIDTH-1:0] head;
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fullpop_clear got %b want 0", overflow); end
        div = 8'd0;
        sample_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            lfsr_data = 8'(8'h40 + i);
            step();
        end
        checks++; if (level !== 5'd16) begin errors++; $display("FAIL fullpop_fill got %0d want 16", level); end
        m_axis_tready = 1'b1;
        for (int i = 0; i < 24; i++) begin
            head = (i < 16) ? 8'(8'h40 + i) : 8'(8'h60 + i - 16);
            checks++;
            if (m_axis_tdata !== head) begin errors++; $display("FAIL fullpop_order[%0d] got %h want %h", i, m_axis_tdata, head); end
            lfsr_data = 8'(8'h60 + i);
            step();
            checks++;
            if (level !== 5'd16 || overflow !== 1'b0) begin
                errors++; $display("FAIL fullpop_steady[%0d] got level=%0d ovf=%b want level=16 ovf=0", i, level, overflow);
            end
        end
        sample_en = 1'b0;
        for (int i = 0; i < 16; i++) step();
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL fullpop_drain got %b want 0", m_axis_tvalid); end
        m_axis_tready = 1'b0;
    endtask

    task automatic test_flush_clear();
        div = 8'd0;
        m_axis_tready = 1'b0;
        sample_en = 1'b1;
        for (int i = 0; i < 17; i++) begin
            lfsr_data = 8'(8'h80 + i);
            step();
        end
        sample_en = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        sample_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            lfsr_data = 8'(8'hB0 + i);
            step();
        end
        checks++;
        if (level !== 5'd5 || overflow !== 1'b1 || m_axis_tdata !== 8'hB0) begin
            errors++; $display("FAIL flush_setup got level=%0d ovf=%b d=%h want level=5 ovf=1 d=b0", level, overflow, m_axis_tdata);
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        sample_en = 1'b0;
        checks++; if (level !== 5'd0 || m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL flush_empty got level=%0d v=%b want level=0 v=0", level, m_axis_tvalid); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL flush_keeps_ovf got %b want 1", overflow); end
        checks++; if (drop_count !== (DC_EN ? 8'd1 : 8'd0)) begin errors++; $display("FAIL flush_keeps_drops got %0d want %0d", drop_count, DC_EN ? 1 : 0); end
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        checks++; if (overflow !== 1'b0 || drop_count !== 8'h00) begin errors++; $display("FAIL clr_ovf got ovf=%b drops=%0d want ovf=0 drops=0", overflow, drop_count); end
        sample_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            lfsr_data = 8'(i);
            step();
        end
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        sample_en = 1'b0;
        checks++;
        if (overflow !== 1'b1 || drop_count !== (DC_EN ? 8'd1 : 8'd0)) begin
            errors++; $display("FAIL clr_vs_drop got ovf=%b drops=%0d want ovf=1 drops=%0d", overflow, drop_count, DC_EN ? 1 : 0);
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    task automatic test_reset_mid();
        div = 8'd0;
        m_axis_tready = 1'b0;
        sample_en = 1'b1;
        for (int i = 0; i < 17; i++) begin
            lfsr_data = 8'(8'h20 + i);
            step();
        end
        sample_en = 1'b0;
        m_axis_tready = 1'b1;
        for (int i = 0; i < 9; i++) step();
        m_axis_tready = 1'b0;
        div = 8'd3;
        sample_en = 1'b1;
        step();
        step();
        checks++; if (level !== 5'd7 || overflow !== 1'b1) begin errors++; $display("FAIL rstmid_setup got level=%0d ovf=%b want level=7 ovf=1", level, overflow); end
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        sample_en = 1'b0;
        checks++;
        if (level !== 5'd0 || m_axis_tvalid !== 1'b0 || overflow !== 1'b0 || drop_count !== 8'h00) begin
            errors++; $display("FAIL rstmid_outputs got level=%0d v=%b ovf=%b drops=%0d want 0 0 0 0", level, m_axis_tvalid, overflow, drop_count);
        end
        sample_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            lfsr_data = 8'(8'hC0 + k);
            step();
            if (k < 3) begin
                checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL rstmid_early[%0d] got %b want 0", k, m_axis_tvalid); end
            end
        end
        checks++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 8'hC3) begin
            errors++; $display("FAIL rstmid_first got v=%b d=%h want v=1 d=c3", m_axis_tvalid, m_axis_tdata);
        end
        sample_en = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    task automatic test_random();
        for (int n = 0; n < 800; n++) begin
            sample_en = ($urandom_range(0, 3) != 0);
            lfsr_data = 8'($urandom);
            div = 8'($urandom_range(0, 3));
            m_axis_tready = ($urandom_range(0, 4) < 2);
            flush = ($urandom_range(0, 63) == 0);
            clr_ovf = ($urandom_range(0, 31) == 0);
            resetn = ($urandom_range(0, 299) != 0);
            step();
            checks++;
            if (m_axis_tvalid !== (exp_q.size() != 0) || int'(level) != exp_q.size() || overflow !== m_ovf || int'(drop_count) != exp_dc()) begin
                errors++;
                $display("FAIL rand_status[%0d] got v=%b level=%0d ovf=%b drops=%0d want v=%b level=%0d ovf=%b drops=%0d",
                         n, m_axis_tvalid, level, overflow, drop_count, exp_q.size() != 0, exp_q.size(), m_ovf, exp_dc());
            end
            if (exp_q.size() != 0) begin
                checks++;
                if (m_axis_tdata !== exp_q[0]) begin errors++; $display("FAIL rand_tdata[%0d] got %h want %h", n, m_axis_tdata, exp_q[0]); end
            end
        end
        resetn = 1'b1;
        idle_inputs();
        step();
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_decimation();
        test_overflow();
        test_full_pop();
        test_flush_clear();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
